pow2_approx_pipe: RTL
=====================

Name: pow2_approx_pipe

Overview:
- Inverse of the Q4.12 Mitchell log2 approximator: maps a Q4.12 log2-domain value back to the linear Q4.12 domain as (1.f) * 2^e.
- Sits after log-domain arithmetic (softmax/division datapath) and converts results back to linear.
- 2-stage elastic pipeline with valid/ready handshake on both sides; full throughput of one result per clock.

Parameters:
- W, 16, total data width.
- FRAC_W, 12, fractional bits. INT_W = W - FRAC_W. Constraint: 2^INT_W - INT_W <= FRAC_W. Only the defaults are verified.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_log2 is valid.
- in_ready  out  1  block accepts in_log2 this cycle.
- in_log2  in  16  Q4.12 log2 value: [15:12] exponent field, [11:0] fraction f.
- out_valid  out  1  out_x is valid.
- out_ready  in  1  downstream accepts out_x.
- out_x  out  16  Q4.12 unsigned linear result.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. During reset, all valid flags clear.
- Reset values: out_valid=0, out_x=0x0000, in_ready=1 (combinational, once both stages are empty).
- Exponent decode (exponent field wraps, matching the log2 encoder range -12..3):
  - e = field when field <= INT_W-1 (0..3).
  - e = field - 16 otherwise (4..15 map to -12..-1).
- Mantissa: m = {1'b1, f}, 13 bits. Result value = m * 2^e, with 0x1000 = 1.0.
  - e >= 0: out_x = m << e. Maximum is 0x1FFF<<3 = 0xFFF8, so overflow cannot occur.
  - e < 0: out_x = m >> (-e), truncated. Minimum nonzero is 0x0001 at e=-12. Output is never 0.
- Stage 1 (S1): on an accepted input, register the decoded shift direction, shift amount (0..12) and m; s1_valid=1.
- Stage 2 (S2): barrel-shift the S1 contents and register out_x; s2_valid drives out_valid.
- Handshake:
  - Transfer on a port occurs when valid && ready are both high in the same cycle.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, a combinational function of state and out_ready only. No combinational path from in_valid.
- Latency: an accepted input appears on out_x with out_valid=1 two cycles later when out_ready is held high.
- Back-to-back: one accept per cycle with no bubbles while out_ready=1.
- Stall: out_x and out_valid hold stable while out_valid && !out_ready. in_valid deasserting never alters held data.
- Both stages full and out_ready=0: in_ready=0, no input is consumed.
- Simultaneous pop and push: when both stages are full and out_ready=1, the S2 pop, S1->S2 move and new-input accept all occur in the same cycle.
- Reset mid-operation: all in-flight data is discarded, out_valid drops asynchronously, and no spurious output follows release.

Optional Feature:
- Macro: POW2_ROUND_EN.
- Defined: right shifts round half-up. out_x = (m + (1 << (-e-1))) >> (-e) for e<0; left shifts are unchanged. The rounding adder sits in S2, so latency is unchanged. A carry can produce a power-of-two result, e.g. 0x1000 from 0x1FFF>>1 rounded.
- Undefined: right shifts truncate as above.

Decomposition:
- Package pow2_pkg:
  - Q4.12 constants: W, FRAC_W, INT_W, Q_ONE=16'h1000.
  - Exponent range constants E_MAX=3, E_MIN=-12.
  - Shift-amount width constant SH_W=4.
- Sub-module pow2_shifter (combinational): takes m, direction and amount, plus the rounding path under POW2_ROUND_EN; returns the 16-bit result. It is instantiated in S2.

Test Plan:
- in_log2=0x0000, out_ready=1 -> out_x=0x1000 exactly 2 cycles after accept; in_log2=0x3FFF -> 0xFFF8.
- Negative exponents:
  - 0xF800 -> 0x0C00.
  - 0x4000 -> 0x0001.
  - 0xF001 -> 0x0800 without POW2_ROUND_EN, 0x0801 with it.
- Round trip through log2 encoder:
  - linear 0x2A5C -> log2 0x152E -> pow2 returns 0x2A5C.
  - Sweep every linear input whose set bits fit in a 13-bit window -> exact reconstruction.
- Backpressure: stream 6 inputs with out_ready=0 for 5 cycles -> in_ready falls after 2 accepts, out_x stays stable, all 6 results emerge in order with none lost or duplicated.
- Full throughput: 100 random inputs, in_valid and out_ready held at 1 -> 100 outputs on consecutive cycles matching the reference model.
- Reset with both stages full: rst_n low mid-stream -> out_valid=0 immediately. After release, in_ready=1 and no output appears until a new input is accepted.

Source files
------------

// File: rtl/pow2_pkg.sv
// Shared constants and types for the Q4.12 pow2 (antilog) pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pow2_pkg;

    // Q4.12 fixed-point format
    localparam int          W      = 16;
    localparam int          FRAC_W = 12;
    localparam int          INT_W  = W - FRAC_W;
    localparam logic [15:0] Q_ONE  = 16'h1000;

    // Exponent range covered by the wrapped 4-bit exponent field
    localparam int E_MAX = 3;
    localparam int E_MIN = -12;

    // Shift amount 0..12 fits in 4 bits
    localparam int SH_W = 4;

    // Mantissa with the implicit leading one
    localparam int M_W = FRAC_W + 1;

    typedef enum logic {
        SH_LEFT  = 1'b0,
        SH_RIGHT = 1'b1
    } sh_dir_e;

    // Stage-1 register contents: decoded shift and mantissa
    typedef struct packed {
        sh_dir_e         dir;
        logic [SH_W-1:0] amt;
        logic [M_W-1:0]  m;
    } s1_t;

endpackage

// File: rtl/pow2_shifter.sv
// Combinational barrel shifter: x = m << amt (left) or m >> amt (right).
// Latency: 0 cycles (pure combinational, lives in stage 2).
// Backpressure: none; POW2_ROUND_EN selects round-half-up on right shifts.
// Ports: m (13b mantissa 1.f), dir (shift direction), amt (0..12), x (16b Q4.12 result).
module pow2_shifter
    import pow2_pkg::*;
(
    input  logic [M_W-1:0]  m,
    input  sh_dir_e         dir,
    input  logic [SH_W-1:0] amt,
    output logic [W-1:0]    x
);

    logic [W-1:0] m_ext;
    assign m_ext = {{(W - M_W){1'b0}}, m};

`ifdef POW2_ROUND_EN
    localparam logic [W-1:0] ONE_W = {{(W - 1){1'b0}}, 1'b1};

    // Half an output LSB; right shifts always have amt >= 1.
    // Worst case 0x1FFF + 0x0800 still fits in 16 bits.
    logic [W-1:0] half;
    assign half = (ONE_W << amt) >> 1;
`endif

    always_comb begin
        x = '0;
        if (dir == SH_LEFT) begin
            // amt <= 3, so 0x1FFF << 3 = 0xFFF8 cannot overflow
            x = m_ext << amt;
        end else begin
`ifdef POW2_ROUND_EN
            x = (m_ext + half) >> amt;
`else
            x = m_ext >> amt;
`endif
        end
    end

endmodule

// File: rtl/pow2_approx_pipe.sv
// Q4.12 log2 -> linear converter, result = (1.f) * 2^e, exponent field wraps to -12..3.
// Latency: 2 cycles (decode reg, shift reg); one result per clock.
// Backpressure: elastic valid/ready, in_ready = stage-1 can advance; outputs hold while stalled.
// Ports: clk, rst_n (async active-low), in_valid/in_ready/in_log2 (Q4.12 log2),
//        out_valid/out_ready/out_x (Q4.12 linear). Option: POW2_ROUND_EN rounds right shifts.
module pow2_approx_pipe #(
    parameter int W      = 16,
    parameter int FRAC_W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_log2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x
);

    import pow2_pkg::*;

    logic [W-FRAC_W-1:0] field;
    s1_t                 s1_d;
    s1_t                 s1_q;
    logic                s1_vld;
    logic [W-1:0]        s2_x;
    logic                s2_vld;
    logic [W-1:0]        shift_x;
    logic                s1_adv;
    logic                s2_adv;

    assign field = in_log2[W-1:FRAC_W];

    // Exponent decode: fields 0..E_MAX are left shifts, larger fields are
    // negative exponents (field - 2^INT_W), i.e. right shift by 2^INT_W - field.
    always_comb begin
        s1_d   = '0;
        s1_d.m = {1'b1, in_log2[FRAC_W-1:0]};
        if (int'(field) <= E_MAX) begin
            s1_d.dir = SH_LEFT;
            s1_d.amt = SH_W'(field);
        end else begin
            s1_d.dir = SH_RIGHT;
            s1_d.amt = SH_W'((1 << (W - FRAC_W)) - int'(field));
        end
    end

    // Each stage advances when it is empty or its successor advances;
    // in_ready depends only on state and out_ready.
    assign s2_adv   = !s2_vld || out_ready;
    assign s1_adv   = !s1_vld || s2_adv;
    assign in_ready = s1_adv;

    pow2_shifter u_shifter (
        .m   (s1_q.m),
        .dir (s1_q.dir),
        .amt (s1_q.amt),
        .x   (shift_x)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
            s2_vld <= 1'b0;
            s2_x   <= '0;
        end else begin
            if (s1_adv) begin
                s1_vld <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_adv) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_x <= shift_x;
                end
            end
        end
    end

    assign out_valid = s2_vld;
    assign out_x     = s2_x;

endmodule
